// File: rtl/text_slot_arbiter_pkg.sv
// Shared types and constants for the VGA text-overlay slot arbiter.
package text_slot_pkg;

  localparam int         GLYPH_W     = 8;
  localparam int         GLYPH_H     = 16;
  localparam logic [6:0] BLANK_ASCII = 7'h20;

  typedef struct packed {
    logic       enable;
    logic [6:0] ascii;
    logic [9:0] sx;
    logic [9:0] sy;
  } slot_t;

  localparam slot_t BLANK_SLOT = '{enable: 1'b0, ascii: BLANK_ASCII, sx: 10'd0, sy: 10'd0};

endpackage

// File: rtl/text_slot_arbiter_if.sv
// Valid/ready slot-table write port of text_slot_arbiter.
interface text_slot_arbiter_if;

  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_slot;
  logic [6:0] wr_ascii;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic       wr_en;

  modport master (output wr_valid, wr_slot, wr_ascii, wr_x, wr_y, wr_en, input wr_ready);
  modport slave  (input wr_valid, wr_slot, wr_ascii, wr_x, wr_y, wr_en, output wr_ready);

endinterface

// File: rtl/text_slot_arbiter_slot_match.sv
// Combinational hit test and glyph offsets for one character slot.
module slot_match
  import text_slot_pkg::*;
(
  input  slot_t      slot,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       video_on,
  output logic       hit,
  output logic [3:0] row_off,
  output logic [2:0] col_off
);

  logic [10:0] x_end;
  logic [10:0] y_end;

  // Widened by one bit so a glyph at the right/bottom edge cannot wrap to 0.
  assign x_end = {1'b0, slot.sx} + 11'(GLYPH_W - 1);
  assign y_end = {1'b0, slot.sy} + 11'(GLYPH_H - 1);

  assign hit = slot.enable && video_on
            && (x >= slot.sx) && ({1'b0, x} <= x_end)
            && (y >= slot.sy) && ({1'b0, y} <= y_end);

  assign col_off = x[2:0] - slot.sx[2:0];
  assign row_off = y[3:0] - slot.sy[3:0];

endmodule

// File: rtl/text_slot_arbiter.sv
// Character-slot table, priority select and ascii_rom pipeline for the text overlay.
// `TEXT_SLOT_SHADOW_EN selects double-buffered tables committed once per frame.
module text_slot_arbiter
  import text_slot_pkg::*;
#(
  parameter int NUM_SLOTS   = 24,
  parameter int ROM_LAT     = 1
`ifdef TEXT_SLOT_SHADOW_EN
  , parameter int COMMIT_LINE = 480
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                video_on,
  text_slot_arbiter_if.slave  wr,
  output logic [10:0]         rom_addr,
  input  logic [7:0]          rom_data,
  output logic                text_bit,
  output logic                text_hit,
  output logic [4:0]          slot_id,
  output logic                commit_pulse
);

  slot_t active_tbl [NUM_SLOTS];
  slot_t wr_entry;
  logic  wr_in_range;
  logic  wr_fire;

  assign wr_entry    = '{enable: wr.wr_en, ascii: wr.wr_ascii, sx: wr.wr_x, sy: wr.wr_y};
  assign wr_in_range = int'(wr.wr_slot) < NUM_SLOTS;
  assign wr_fire     = wr.wr_valid && wr.wr_ready && wr_in_range;

`ifdef TEXT_SLOT_SHADOW_EN
  slot_t pending_tbl [NUM_SLOTS];
  logic  ready_q;
  logic  commit_now;

  assign commit_now   = (y == 10'(COMMIT_LINE)) && (x == 10'd0);
  assign wr.wr_ready  = reset && ready_q && !commit_now;
  assign commit_pulse = reset && commit_now;

  // NOTE: the slot tables are flops rather than RAM, so they can be cleared in a
  // single cycle and the screen is guaranteed blank straight out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pending_tbl[i] <= BLANK_SLOT;
        active_tbl[i]  <= BLANK_SLOT;
      end
    end else begin
      ready_q <= 1'b1;
      if (wr_fire) pending_tbl[wr.wr_slot] <= wr_entry;
      if (commit_now) active_tbl <= pending_tbl;
    end
  end
`else
  assign wr.wr_ready  = reset;
  assign commit_pulse = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) active_tbl[i] <= BLANK_SLOT;
    end else if (wr_fire) begin
      active_tbl[wr.wr_slot] <= wr_entry;
    end
  end
`endif

  logic [NUM_SLOTS-1:0] hit_vec;
  logic [3:0]           row_vec [NUM_SLOTS];
  logic [2:0]           col_vec [NUM_SLOTS];

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_match
    slot_match u_match (
      .slot     (active_tbl[i]),
      .x        (x),
      .y        (y),
      .video_on (video_on),
      .hit      (hit_vec[i]),
      .row_off  (row_vec[i]),
      .col_off  (col_vec[i])
    );
  end

  logic        sel_hit;
  logic [4:0]  sel_id;
  logic [2:0]  sel_col;
  logic [10:0] sel_addr;

  // NOTE: every output gets a default first so no path leaves one unassigned
  // (no latch); blocking assignments let the descending scan keep the lowest hit.
  always_comb begin
    sel_hit  = 1'b0;
    sel_id   = '0;
    sel_col  = '0;
    sel_addr = {BLANK_ASCII, 4'h0};
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_hit  = 1'b1;
        sel_id   = 5'(i);
        sel_col  = col_vec[i];
        sel_addr = {active_tbl[i].ascii, row_vec[i]};
      end
    end
  end

  logic               hit_q;
  logic [2:0]         col_q;
  logic [4:0]         id_q;
  logic [ROM_LAT-1:0] hit_d;
  logic [2:0]         col_d [ROM_LAT];
  logic [4:0]         id_d  [ROM_LAT];

  // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rom_addr <= '0;
      hit_q    <= 1'b0;
      col_q    <= '0;
      id_q     <= '0;
      hit_d    <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        col_d[i] <= '0;
        id_d[i]  <= '0;
      end
    end else begin
      rom_addr <= sel_addr;
      hit_q    <= sel_hit;
      col_q    <= sel_col;
      id_q     <= sel_id;
      hit_d[0] <= hit_q;
      col_d[0] <= col_q;
      id_d[0]  <= id_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        hit_d[i] <= hit_d[i-1];
        col_d[i] <= col_d[i-1];
        id_d[i]  <= id_d[i-1];
      end
    end
  end

  assign text_hit = hit_d[ROM_LAT-1];
  assign slot_id  = id_d[ROM_LAT-1];
  assign text_bit = text_hit && rom_data[3'd7 - col_d[ROM_LAT-1]];

endmodule

// File: tb/tb_text_slot_arbiter.sv
// Scoreboard bench for text_slot_arbiter: a slot-table model predicts each pixel,
// expectations are queued at drive time and popped when the pipeline delivers them.
module tb_text_slot_arbiter;
  import text_slot_pkg::*;

  localparam int NUM_SLOTS = 24;
  localparam int LAT       = 2;
`ifdef TEXT_SLOT_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        video_on = 1'b0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        text_bit;
  logic        text_hit;
  logic [4:0]  slot_id;
  logic        commit_pulse;

  text_slot_arbiter_if wr ();

  text_slot_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .video_on     (video_on),
    .wr           (wr),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .text_bit     (text_bit),
    .text_hit     (text_hit),
    .slot_id      (slot_id),
    .commit_pulse (commit_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [10:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd40503;
    return t[12:5] ^ a[7:0];
  endfunction

  always @(posedge clk) rom_data <= glyph(rom_addr);

  typedef struct {
    logic [10:0] addr;
    logic        hit;
    logic        pix;
    logic [4:0]  id;
  } exp_t;

  slot_t act_m  [NUM_SLOTS];
  slot_t pend_m [NUM_SLOTS];
  logic  rdy_m = 1'b0;
  exp_t  exp_q [$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t predict(input int px, input int py, input logic von);
    exp_t        e;
    int          sx, sy;
    logic [7:0]  g;
    e.addr = {BLANK_ASCII, 4'h0};
    e.hit  = 1'b0;
    e.pix  = 1'b0;
    e.id   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sx = int'(act_m[i].sx);
      sy = int'(act_m[i].sy);
      if (act_m[i].enable && von && px >= sx && px <= sx + 7 && py >= sy && py <= sy + 15) begin
        e.hit  = 1'b1;
        e.id   = 5'(i);
        e.addr = {act_m[i].ascii, 4'(py - sy)};
        g      = glyph(e.addr);
        e.pix  = g[7 - (px - sx)];
        break;
      end
    end
    return e;
  endfunction

  task automatic step(input int px, input int py, input logic von);
    exp_t  e, f;
    exp_t  z;
    logic  cn, rdy_e, fire, rst_s;
    slot_t ent;
    int    s;
    x = 10'(px);
    y = 10'(py);
    video_on = von;
    #1;
    rst_s = reset;
    cn    = SHADOW && reset && py == 480 && px == 0;
    rdy_e = SHADOW ? (reset && rdy_m && !(py == 480 && px == 0)) : reset;
    check("wr_ready", wr.wr_ready, rdy_e);
    check("commit_pulse", commit_pulse, cn);
    e    = predict(px, py, von);
    s    = int'(wr.wr_slot);
    fire = wr.wr_valid && rdy_e && s < NUM_SLOTS;
    ent  = '{enable: wr.wr_en, ascii: wr.wr_ascii, sx: wr.wr_x, sy: wr.wr_y};
    @(posedge clk);
    if (!rst_s) begin
      rdy_m = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        act_m[i]  = BLANK_SLOT;
        pend_m[i] = BLANK_SLOT;
      end
    end else begin
      rdy_m = 1'b1;
      if (cn) act_m = pend_m;
      if (fire) begin
        if (SHADOW) pend_m[s] = ent;
        else        act_m[s]  = ent;
      end
    end
    #1;
    if (!rst_s) begin
      check("rst_rom_addr", rom_addr, 32'd0);
      check("rst_text_hit", text_hit, 32'd0);
      check("rst_text_bit", text_bit, 32'd0);
      check("rst_slot_id", slot_id, 32'd0);
      z = '{addr: '0, hit: 1'b0, pix: 1'b0, id: '0};
      exp_q = {};
      exp_q.push_back(z);
    end else begin
      exp_q.push_back(e);
      check("rom_addr", rom_addr, exp_q[$].addr);
      if (exp_q.size() >= LAT) begin
        f = exp_q.pop_front();
        check("text_hit", text_hit, f.hit);
        check("slot_id", slot_id, f.id);
        check("text_bit", text_bit, f.pix);
      end
    end
  endtask

  task automatic write_slot(input int s, input logic [6:0] a, input int sx, input int sy,
                            input logic en, input int px, input int py);
    wr.wr_valid = 1'b1;
    wr.wr_slot  = 5'(s);
    wr.wr_ascii = a;
    wr.wr_x     = 10'(sx);
    wr.wr_y     = 10'(sy);
    wr.wr_en    = en;
    step(px, py, 1'b0);
    wr.wr_valid = 1'b0;
  endtask

  task automatic commit();
    step(0, 480, 1'b0);
  endtask

  task automatic scan(input int sx, input int sy);
    for (int py = sy - 1; py <= sy + 16; py++)
      for (int px = sx - 1; px <= sx + 8; px++)
        step(px, py, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int i, px, py;
    wr.wr_valid = 1'b0;
    wr.wr_slot  = '0;
    wr.wr_ascii = '0;
    wr.wr_x     = '0;
    wr.wr_y     = '0;
    wr.wr_en    = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      act_m[k]  = BLANK_SLOT;
      pend_m[k] = BLANK_SLOT;
    end

    repeat (3) step(10, 10, 1'b1);
    reset = 1'b1;
    step(0, 0, 1'b0);
    step(1, 0, 1'b0);

    // Basic glyph: slot 3 = 'A' at (100,200).
    write_slot(3, 7'h41, 100, 200, 1'b1, 5, 5);
    step(100, 200, 1'b1);
    commit();
    scan(100, 200);

    // Overlap: lowest index wins until it is disabled.
    write_slot(1, 7'h42, 296, 44, 1'b1, 0, 0);
    write_slot(5, 7'h43, 300, 50, 1'b1, 0, 1);
    commit();
    step(300, 50, 1'b1);
    step(303, 55, 1'b1);
    step(300, 60, 1'b1);
    write_slot(1, 7'h42, 296, 44, 1'b0, 0, 2);
    commit();
    step(300, 50, 1'b1);
    step(303, 55, 1'b1);

    // Mid-frame write is held back until the commit line.
    write_slot(0, 7'h44, 20, 300, 1'b1, 0, 240);
    step(20, 300, 1'b1);
    step(27, 315, 1'b1);
    commit();
    step(20, 300, 1'b1);
    step(27, 315, 1'b1);

    // Bottom-right corner glyph, no wrap-around hits.
    write_slot(7, 7'h45, 632, 472, 1'b1, 0, 3);
    commit();
    step(639, 479, 1'b1);
    step(632, 472, 1'b1);
    step(631, 479, 1'b1);
    step(0, 480, 1'b0);
    step(639, 487, 1'b1);
    step(639, 488, 1'b1);
    step(0, 472, 1'b1);
    step(7, 479, 1'b1);

    // Out-of-range slot index is accepted and dropped.
    write_slot(30, 7'h46, 0, 0, 1'b1, 0, 4);
    commit();
    step(0, 0, 1'b1);
    step(3, 7, 1'b1);

    // Reset mid-frame with four slots active.
    step(100, 100, 1'b1);
    reset = 1'b0;
    step(100, 100, 1'b1);
    step(101, 100, 1'b1);
    reset = 1'b1;
    step(100, 200, 1'b1);
    step(300, 50, 1'b1);
    step(20, 300, 1'b1);
    commit();
    step(100, 200, 1'b1);
    step(639, 479, 1'b1);
    write_slot(3, 7'h41, 100, 200, 1'b1, 0, 5);
    commit();
    step(100, 200, 1'b1);
    step(107, 215, 1'b1);

    // Random traffic around the currently known slot positions.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        write_slot(int'($urandom_range(0, 31)), 7'($urandom_range(32, 126)),
                   int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                   1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 639)), 7);
      end else if ($urandom_range(0, 31) == 0) begin
        commit();
      end else begin
        i  = int'($urandom_range(0, NUM_SLOTS - 1));
        px = int'(act_m[i].sx) + int'($urandom_range(0, 9)) - 1;
        py = int'(act_m[i].sy) + int'($urandom_range(0, 17)) - 1;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        step(px, py, 1'($urandom_range(0, 7) != 0));
      end
    end

    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_slot_arbiter.md
# text_slot_arbiter

Owns the single shared `ascii_rom` for the VGA text overlay. It holds a table of character slots, each with a screen position, an ASCII code and an enable bit, and resolves which slot, if any, covers the current pixel. It issues the ROM address and delivers a pipeline-aligned glyph bit and slot id to the pixel mux. The table is loaded through a valid/ready write port, so the counter and label logic update the display without per-character instances.

## Interface
- `NUM_SLOTS`, 24: number of character slots; must not exceed 32.
- `ROM_LAT`, 1: read latency of `ascii_rom` in cycles.
- `COMMIT_LINE`, 480: value of `y` at which pending writes are committed, in vertical blanking.
- `clk`  in  1  pixel clock.
- `reset`  in  1  synchronous, active-low reset.
- `x`  in  10  current pixel column from `vga_sync`.
- `y`  in  10  current pixel row from `vga_sync`.
- `video_on`  in  1  active-area flag from `vga_sync`.
- `wr_valid`  in  1  slot write request.
- `wr_ready`  out  1  slot write accepted when high together with `wr_valid`.
- `wr_slot`  in  5  slot index; writes with index ≥ `NUM_SLOTS` are accepted and dropped.
- `wr_ascii`  in  7  ASCII code.
- `wr_x`  in  10  glyph top-left column.
- `wr_y`  in  10  glyph top-left row.
- `wr_en`  in  1  slot enable.
- `rom_addr`  out  11  registered address to `ascii_rom`, formed as {ascii, row offset[3:0]}.
- `rom_data`  in  8  ROM output, valid `ROM_LAT` cycles after `rom_addr`.
- `text_bit`  out  1  glyph pixel on, aligned to `rom_data`.
- `text_hit`  out  1  some enabled slot covers the pixel, aligned to `text_bit`.
- `slot_id`  out  5  index of the winning slot, aligned to `text_bit`.
- `commit_pulse`  out  1  one-cycle pulse when the pending table is copied to the active table.

## Operation
- Glyph size is fixed at 8×16.
- Slot i hits when all of the following hold:
  - the slot is enabled;
  - `video_on` is high;
  - `x` is in [sx, sx+7] and `y` is in [sy, sy+15];
  - comparisons use 11-bit arithmetic, so sx+7 never wraps.
- The lowest hitting index wins. Overlapping slots never blend.
- Row offset is `y`−sy and column offset is `x`−sx, each truncated to 4 and 3 bits. Glyph placement is independent of `y[3:0]` alignment.
- When no slot hits:
  - `rom_addr` takes {7'h20, 4'h0};
  - `text_hit` is 0, `text_bit` is 0 and `slot_id` is 0.
- `text_bit` is `rom_data[7 − col_offset]`, delayed to match. The MSB is the leftmost pixel.
- Write port: a transfer occurs on a cycle where `wr_valid` and `wr_ready` are both high. It writes all four fields of the pending table entry `wr_slot`.
- Commit: on the cycle where `y` equals `COMMIT_LINE` and `x` equals 0:
  - the whole pending table is copied to the active table;
  - `commit_pulse` asserts for that cycle;
  - `wr_ready` is 0 for that cycle only.
- A write on the cycle before the commit is included in that commit.
- Repeated writes to one slot within a frame: the last write wins.
- Reset:
  - all pending and active slots are disabled, ascii 7'h20, position 0;
  - all pipeline registers are cleared, so `rom_addr` is 0 and all outputs are 0;
  - `wr_ready` is 0 while `reset` is low and 1 from the first cycle after it is released.
- Reset asserted mid-frame clears the active table immediately. The next frame blanks until writes and a commit occur.

## Timing
- Stage 0: `x` and `y` are sampled; compare and priority select are combinational.
- Stage 1: `rom_addr`, hit, column offset and slot id are registered.
- Stages 2 through 1+`ROM_LAT`: hit, column offset and slot id are delayed by `ROM_LAT` registers.
- Total latency from `x`/`y` to `text_bit` is 1+`ROM_LAT` cycles, which is 2 at the default. Downstream delays `video_on`, `hsync` and `vsync` by the same amount.
- Throughput: one pixel per clock with no stalls.
- A write is visible on screen at the first commit after it is accepted. It is never visible mid-frame.

## Configuration
- `TEXT_SLOT_SHADOW_EN`
  - Defined: the double-buffered pending/active tables, the commit behaviour and `commit_pulse` are compiled in, as described above.
  - Undefined:
    - the pending table is removed;
    - writes go directly to the active table and take effect from the next cycle, so tearing is accepted;
    - `wr_ready` is 1 whenever `reset` is high;
    - `commit_pulse` is tied to 0.

## Structure
- Shared package `text_slot_pkg`:
  - `slot_t` struct containing enable, ascii[6:0], sx[9:0] and sy[9:0];
  - constants `GLYPH_W` = 8, `GLYPH_H` = 16 and `BLANK_ASCII` = 7'h20.
- One sub-module, `slot_match`: the combinational per-slot hit test and offset generator, instantiated `NUM_SLOTS` times. The priority encoder and the pipeline live in the top module.

## Test plan
- Write slot 3 = {'A', 100, 200, en}, then run to commit. At `x`=100, `y`=200, `rom_addr` is {7'h41, 4'h0} one cycle later. `text_bit` equals the ROM bit 7 two cycles later and `slot_id` is 3.
- Slots 1 and 5 overlap at (300, 50). The pixel reports `slot_id` 1 and slot 1's ascii. After slot 1 is disabled and a commit runs, it reports 5.
- Write slot 0 mid-frame at `y`=240. The glyph is absent for rows 240–479 of that frame and present in the next frame. `commit_pulse` fires at `y`=480, `x`=0, and `wr_ready` is low for that one cycle.
- Slot at (632, 472). Pixel (639, 479) hits with column offset 7 and row offset 7, and pixel (0, 480) with `video_on` 0 misses. Check no false hit from wrap.
- Assert `reset` low at `y`=100 with 4 slots active. All outputs are 0 the next cycle, `wr_ready` is 0 during reset, and there are no hits until a new write and commit.
- Write with `wr_slot`=30 and `NUM_SLOTS`=24. The write is accepted, the table is unchanged and there is no hit anywhere.
